dac_req_arbiter: RTL

DAC_REQ_ARBITER -- requirements
Module: dac_req_arbiter

---
 rtl/dac_req_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dac_req_arbiter.sv
// -----------------------------------------------------------------------------
// dac_req_arbiter
//
// Shares one dual-channel SPI DAC between NUM_REQ requesters. Each channel has
// a one-entry pending buffer. Requesters are accepted round-robin, and only
// into an empty buffer. A programmable slot timer ticks once per rate_div_i
// cycles. On each tick, every full buffer is copied to its channel outputs,
// the buffer is emptied, and that channel's update strobe pulses for one
// cycle.
//
// Ports
//   clk          in   single clock
//   rst_i        in   synchronous active-high reset
//   en_i         in   scheduling enable (gates acceptance, timer and strobes)
//   rate_div_i   in   update slot period in clk cycles (0 and 1 both = every cycle)
//   req_valid_i  in   per-requester request valid
//   req_ready_o  out  per-requester accept, one-hot or zero, combinational
//   req_chan_i   in   per-requester target channel (0 = ch0, 1 = ch1)
//   req_data_i   in   per-requester 12-bit code, requester k at [12k+11:12k]
//   req_pd_i     in   per-requester 2-bit mode, requester k at [2k+1:2k]
//   dac_en_o     out  en_i delayed by one register stage
//   dac_data0_o  out  channel 0 code       dac_data1_o  out  channel 1 code
//   dac_pd0_o    out  channel 0 mode       dac_pd1_o    out  channel 1 mode
//   dac_upd0_o   out  channel 0 strobe     dac_upd1_o   out  channel 1 strobe
//   grant_id_o   out  index of the last accepted requester
// -----------------------------------------------------------------------------
module dac_req_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [15:0]           rate_div_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_chan_i,
    input  logic [12*NUM_REQ-1:0] req_data_i,
    input  logic [2*NUM_REQ-1:0]  req_pd_i,
    output logic                  dac_en_o,
    output logic [11:0]           dac_data0_o,
    output logic [11:0]           dac_data1_o,
    output logic [1:0]            dac_pd0_o,
    output logic [1:0]            dac_pd1_o,
    output logic                  dac_upd0_o,
    output logic                  dac_upd1_o,
    output logic [IDW-1:0]        grant_id_o
);

    // Pending buffers, indexed by channel.
    logic [1:0]         full;
    logic [11:0]        pend_data [2];
    logic [1:0]         pend_pd   [2];

    logic [IDW-1:0]     rr_ptr;
    logic [15:0]        slot_cnt;
    logic [15:0]        slot_last;
    logic               tick;
    logic [1:0]         issue;

    logic [NUM_REQ-1:0] eligible;
    logic               found_hi;
    logic               found_lo;
    logic [IDW-1:0]     id_hi;
    logic [IDW-1:0]     id_lo;
    logic               xfer;
    logic [IDW-1:0]     xfer_id;
    logic               xfer_chan;
    logic [11:0]        xfer_data;
    logic [1:0]         xfer_pd;
    logic [1:0]         load;

    // Slot timer terminal value. The >= compare makes a shortened period take
    // effect at once: a count already past the new terminal ticks and wraps.
    always_comb begin
        slot_last = (rate_div_i == 16'd0) ? 16'd0 : rate_div_i - 16'd1;
        tick      = en_i && (slot_cnt >= slot_last);
        issue     = full & {2{tick}};
    end

    // Round-robin pick. The first pass finds the lowest eligible index at or
    // above rr_ptr. The second finds the lowest eligible index overall, which
    // is the wrap-around winner. Eligibility uses the registered full flag, so
    // a channel emptied by this cycle's tick only accepts from the next cycle.
    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eligible    = '0;
        found_hi    = 1'b0;
        found_lo    = 1'b0;
        id_hi       = '0;
        id_lo       = '0;
        req_ready_o = '0;
        xfer_chan   = 1'b0;
        xfer_data   = '0;
        xfer_pd     = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = en_i && !rst_i && req_valid_i[k] && !full[req_chan_i[k]];
            if (eligible[k] && !found_hi && (k >= int'(rr_ptr))) begin
                found_hi = 1'b1;
                id_hi    = IDW'(k);
            end
            if (eligible[k] && !found_lo) begin
                found_lo = 1'b1;
                id_lo    = IDW'(k);
            end
        end

        xfer    = found_lo;
        xfer_id = found_hi ? id_hi : id_lo;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (xfer && (IDW'(k) == xfer_id)) begin
                req_ready_o[k] = 1'b1;
                xfer_chan      = req_chan_i[k];
                xfer_data      = req_data_i[12*k +: 12];
                xfer_pd        = req_pd_i[2*k +: 2];
            end
        end

        load = xfer ? (xfer_chan ? 2'b10 : 2'b01) : 2'b00;
    end

    // Control state and DAC outputs. A tick only empties buffers that were
    // already full. A transfer only targets a buffer that was empty. The clear
    // and the set therefore never hit the same flag in one cycle.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            full        <= '0;
            rr_ptr      <= '0;
            grant_id_o  <= '0;
            slot_cnt    <= '0;
            dac_en_o    <= 1'b0;
            dac_data0_o <= '0;
            dac_data1_o <= '0;
            dac_pd0_o   <= '0;
            dac_pd1_o   <= '0;
            dac_upd0_o  <= 1'b0;
            dac_upd1_o  <= 1'b0;
        end else begin
            dac_en_o   <= en_i;
            slot_cnt   <= (tick || !en_i) ? 16'd0 : slot_cnt + 16'd1;
            dac_upd0_o <= issue[0];
            dac_upd1_o <= issue[1];
            if (issue[0]) begin
                dac_data0_o <= pend_data[0];
                dac_pd0_o   <= pend_pd[0];
            end
            if (issue[1]) begin
                dac_data1_o <= pend_data[1];
                dac_pd1_o   <= pend_pd[1];
            end
            full <= (full & ~issue) | load;
            if (xfer) begin
                grant_id_o <= xfer_id;
                rr_ptr     <= (int'(xfer_id) == NUM_REQ - 1) ? '0 : xfer_id + IDW'(1);
            end
        end
    end

    // NOTE: the pending storage has no reset. Its contents matter only while
    // the matching full flag is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            pend_data[xfer_chan] <= xfer_data;
            pend_pd[xfer_chan]   <= xfer_pd;
        end
    end

endmodule
